mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed memory target; the responder end of the single-port read/write memory interface driven by the DMA engine and other initiators in the top.
- Holds DEPTH x 32-bit words and zero-fills the array after reset.
- Services one read and one write per cycle.
- Reports illegal accesses and keeps access counters for the bench and perf monitoring.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal word index range is 0..DEPTH-1.
- READ_LATENCY, 0, read pipeline stages, range 0..3.
  - 0: combinational read. Data is valid in the same cycle mem_read_en is high, which is what the DMA initiator requires because it captures one edge after issue.
- AW, $clog2(DEPTH), internal index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_read_en  in  1  read request, sampled every cycle.
- mem_read_addr  in  32  word index.
- mem_read_data  out  32  read data.
- mem_read_valid  out  1  high in the cycle mem_read_data carries a response.
- mem_write_en  in  1  write request.
- mem_write_addr  in  32  word index.
- mem_write_data  in  32  write data.
- init_done  out  1  high once zero-fill is complete; the top gates initiator start with it.
- access_err  out  1  sticky error flag.
- err_addr  out  32  index of the first failing access since the last clear.
- err_clr  in  1  synchronous clear of access_err and err_addr.
- rd_count  out  32  accepted reads, wraps modulo 2^32.
- wr_count  out  32  accepted writes, wraps modulo 2^32.

Behaviour:
- Reset values: init_done=0, access_err=0, err_addr=0, rd_count=0, wr_count=0, mem_read_data=0, mem_read_valid=0, pipeline cleared, FSM in INIT, sweep index 0.
- FSM states: INIT and READY.
  - INIT: write 0 to array[idx] each cycle, idx increments.
  - After writing idx=DEPTH-1, go to READY and set init_done=1 on the next edge. Zero-fill takes exactly DEPTH cycles.
  - READY is terminal until reset.
- Requests during INIT: ignored, with no array change and no counter change.
  - If access_err=0, set access_err=1 and capture err_addr = the request address (read address if both requests are present).
  - A read during INIT with READ_LATENCY=0 returns 0 with mem_read_valid=1.
- Legal read (READY, addr<DEPTH): rd_count+1.
  - L=0: mem_read_valid=mem_read_en and mem_read_data=array[addr] combinationally. A hold register keeps the last response while mem_read_en=0.
  - L>0: data and valid appear exactly L cycles after the request edge; output holds between responses.
- Legal write (READY, addr<DEPTH): array[addr]<=data at the clock edge; wr_count+1.
- Out-of-range access (addr>=DEPTH):
  - Write is dropped.
  - Read returns 32'h0000_0000 with normal valid and latency.
  - The counter does not increment.
  - access_err set; err_addr captured only if access_err was 0.
- Read and write in the same cycle, same address: read-first by default, i.e. the read returns the old word (see Optional Feature).
- err_clr: clears access_err and err_addr; an error in the same cycle wins (flag stays set, new address captured).
- Counters wrap with no saturation.
- Reset asserted mid-operation: all state returns to reset values immediately, in-flight responses are discarded, and zero-fill restarts.

Optional Feature:
- MEM_WR_FORWARD_EN
  - Defined: a same-cycle read and write to the same legal address returns mem_write_data (write-first forwarding), at the read's normal latency.
  - Undefined: read-first behaviour, returning the pre-write word.

Test Plan:
- Reset with DEPTH=16 -> init_done rises after exactly 16 cycles; reading all 16 words returns 0; rd_count=16; access_err=0.
- READY, L=0: write 0xA5A5_0001 to idx 5, then read idx 5 next cycle -> mem_read_data=0xA5A5_0001 with mem_read_valid=1 in the same cycle; wr_count=1, rd_count=1.
- DMA integration, L=0: copy 4 words from idx 0..3 preloaded with 0x11,0x22,0x33,0x44 to idx 8..11 -> readback at 8..11 matches; rd_count=4, wr_count=4; done pulses once.
- Same cycle: write 0xBEEF to idx 3 (old value 0x1234) and read idx 3 -> returns 0x1234 without the macro, 0xBEEF with MEM_WR_FORWARD_EN; idx 3 holds 0xBEEF in both builds.
- Read idx 20, then write idx 30, with DEPTH=16 -> read data 0, access_err=1, err_addr=20, counters unchanged; assert err_clr -> access_err=0, err_addr=0.
- READ_LATENCY=2: back-to-back reads of idx 1,2 -> responses arrive 2 and 3 cycles after the first request with valid high both cycles. Assert rst_n low mid-stream -> no further valid, init_done=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target for the single-port read/write
// memory interface.
//  - Zero-fills the array after reset, then services one read and one write
//    per cycle.
//  - Flags illegal accesses: requests during zero-fill and out-of-range
//    indices. The first failing index is captured until it is cleared.
//  - Counts accepted reads and writes.
//  - READ_LATENCY = 0 gives a combinational read. READ_LATENCY = 1..3 gives
//    a pipelined read with output hold between responses.
//  - Optional build macro MEM_WR_FORWARD_EN: a same-cycle read and write to
//    the same legal index returns the write data (write-first). Without the
//    macro the read returns the pre-write word (read-first).
module mem_responder #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 0,
    parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en,
    input  logic [31:0] mem_read_addr,
    output logic [31:0] mem_read_data,
    output logic        mem_read_valid,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_addr,
    input  logic [31:0] mem_write_data,
    output logic        init_done,
    output logic        access_err,
    output logic [31:0] err_addr,
    input  logic        err_clr,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic          init_done_reg, init_done_next;
    logic          fill_we;

    logic [31:0]   mem_array [DEPTH];

    logic          ready;
    logic          rd_in_range, wr_in_range;
    logic          rd_ok, wr_ok;
    logic          rd_err, wr_err;
    logic [31:0]   err_addr_sel;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [31:0]   rd_word;

    logic          access_err_reg;
    logic [31:0]   err_addr_reg;
    logic [31:0]   rd_count_reg, wr_count_reg;

    // Request qualification.
    // Only READY and in-range requests touch the array or the counters.
    assign ready       = (state_reg == ST_READY);
    assign rd_in_range = (mem_read_addr  < 32'(DEPTH));
    assign wr_in_range = (mem_write_addr < 32'(DEPTH));
    assign rd_ok       = mem_read_en  && ready && rd_in_range;
    assign wr_ok       = mem_write_en && ready && wr_in_range;
    assign rd_err      = mem_read_en  && !(ready && rd_in_range);
    assign wr_err      = mem_write_en && !(ready && wr_in_range);
    // When both requests fail in the same cycle, the read index is reported.
    assign err_addr_sel = rd_err ? mem_read_addr : mem_write_addr;
    assign rd_idx      = mem_read_addr[AW-1:0];
    assign wr_idx      = mem_write_addr[AW-1:0];

    // FSM state register: sweep index and init_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            idx_reg       <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            init_done_reg <= init_done_next;
        end
    end

    // FSM next-state logic.
    // INIT writes one zero per cycle. It leaves after the last index, so the
    // fill takes exactly DEPTH cycles. READY is terminal until reset.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        init_done_next = init_done_reg;
        fill_we        = 1'b0;
        case (state_reg)
            ST_INIT: begin
                fill_we = 1'b1;
                if (idx_reg == AW'(DEPTH - 1)) begin
                    state_next     = ST_READY;
                    init_done_next = 1'b1;
                end else begin
                    idx_next = idx_reg + AW'(1);
                end
            end
            ST_READY: begin
                state_next     = ST_READY;
                init_done_next = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Array write port.
    // The zero-fill owns the port during INIT; otherwise accepted writes use it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_array[idx_reg] <= '0;
        end else if (wr_ok) begin
            mem_array[wr_idx] <= mem_write_data;
        end
    end

    // Read word selection.
    // Illegal reads return zero. Forwarding is enabled only by the build macro.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem_array[rd_idx];
`ifdef MEM_WR_FORWARD_EN
            if (wr_ok && (mem_write_addr == mem_read_addr)) begin
                rd_word = mem_write_data;
            end
`endif
        end
    end

    // Read response path, selected by latency.
    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            logic [31:0] hold_reg;

            // Hold the last response so the data bus is stable while idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else if (mem_read_en) begin
                    hold_reg <= rd_word;
                end
            end

            assign mem_read_valid = mem_read_en;
            assign mem_read_data  = mem_read_en ? rd_word : hold_reg;
        end else begin : g_pipe_read
            logic [READ_LATENCY-1:0] pv_reg;
            logic [31:0]             pd_reg [READ_LATENCY];

            // Delay line for valid and data.
            // Each data stage only loads when a valid response enters it, so
            // the output keeps the last response between responses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv_reg <= '0;
                    for (int i = 0; i < READ_LATENCY; i++) begin
                        pd_reg[i] <= '0;
                    end
                end else begin
                    pv_reg[0] <= mem_read_en;
                    if (mem_read_en) begin
                        pd_reg[0] <= rd_word;
                    end
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        pv_reg[i] <= pv_reg[i-1];
                        if (pv_reg[i-1]) begin
                            pd_reg[i] <= pd_reg[i-1];
                        end
                    end
                end
            end

            assign mem_read_valid = pv_reg[READ_LATENCY-1];
            assign mem_read_data  = pd_reg[READ_LATENCY-1];
        end
    endgenerate

    // Error flag, error address and access counters.
    // A new error wins over err_clr in the same cycle. The address is only
    // captured when the flag is clear or is being cleared this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access_err_reg <= 1'b0;
            err_addr_reg   <= '0;
            rd_count_reg   <= '0;
            wr_count_reg   <= '0;
        end else begin
            if (rd_ok) begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if (wr_ok) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end
            if (rd_err || wr_err) begin
                access_err_reg <= 1'b1;
                if (!access_err_reg || err_clr) begin
                    err_addr_reg <= err_addr_sel;
                end
            end else if (err_clr) begin
                access_err_reg <= 1'b0;
                err_addr_reg   <= '0;
            end
        end
    end

    assign init_done  = init_done_reg;
    assign access_err = access_err_reg;
    assign err_addr   = err_addr_reg;
    assign rd_count   = rd_count_reg;
    assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed stimulus for mem_responder.
// Two instances share all inputs: one with READ_LATENCY=0 and one with
// READ_LATENCY=2, both with DEPTH=16. A behavioural model predicts every
// output each cycle. Build with +define+MEM_WR_FORWARD_EN to select the
// write-first variant.
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int LAT2  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren, wen, clr;
    logic [31:0] raddr, waddr, wdata;

    logic [31:0] rdata0, erraddr0, rdc0, wrc0;
    logic        rvalid0, idone0, err0;
    logic [31:0] rdata2, erraddr2, rdc2, wrc2;
    logic        rvalid2, idone2, err2;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_en(ren), .mem_read_addr(raddr),
        .mem_read_data(rdata0), .mem_read_valid(rvalid0),
        .mem_write_en(wen), .mem_write_addr(waddr), .mem_write_data(wdata),
        .init_done(idone0), .access_err(err0), .err_addr(erraddr0),
        .err_clr(clr), .rd_count(rdc0), .wr_count(wrc0)
    );

    mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(LAT2)) u_l2 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_en(ren), .mem_read_addr(raddr),
        .mem_read_data(rdata2), .mem_read_valid(rvalid2),
        .mem_write_en(wen), .mem_write_addr(waddr), .mem_write_data(wdata),
        .init_done(idone2), .access_err(err2), .err_addr(erraddr2),
        .err_clr(clr), .rd_count(rdc2), .wr_count(wrc2)
    );

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    int          fill_cnt;
    bit          m_err;
    logic [31:0] m_err_addr, m_rdc, m_wrc, m_hold0, m_hold2;
    bit          m_valid2;
    bit          qv[$];
    logic [31:0] qd[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return fill_cnt == DEPTH;
    endfunction

    // Word a read in the current cycle returns, before this cycle's write.
    function automatic logic [31:0] m_word();
        logic [31:0] w;
        w = 32'h0;
        if (ren && m_ready() && raddr < 32'(DEPTH)) begin
            w = m_mem[int'(raddr)];
`ifdef MEM_WR_FORWARD_EN
            if (wen && waddr == raddr) w = wdata;
`endif
        end
        return w;
    endfunction

    task automatic model_reset();
        fill_cnt   = 0;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
        m_rdc      = 32'h0;
        m_wrc      = 32'h0;
        m_hold0    = 32'h0;
        m_hold2    = 32'h0;
        m_valid2   = 1'b0;
        qv.delete();
        qd.delete();
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input logic [31:0] word);
        bit rbad, wbad, rleg, wleg;
        rleg = ren && m_ready() && raddr < 32'(DEPTH);
        wleg = wen && m_ready() && waddr < 32'(DEPTH);
        rbad = ren && !rleg;
        wbad = wen && !wleg;
        if (rbad || wbad) begin
            if (!m_err || clr) m_err_addr = rbad ? raddr : waddr;
            m_err = 1'b1;
        end else if (clr) begin
            m_err      = 1'b0;
            m_err_addr = 32'h0;
        end
        if (rleg) m_rdc = m_rdc + 32'd1;
        if (wleg) m_wrc = m_wrc + 32'd1;
        if (ren) m_hold0 = word;
        qv.push_back(ren);
        qd.push_back(word);
        if (qv.size() > LAT2) begin
            void'(qv.pop_front());
            void'(qd.pop_front());
        end
        if (qv.size() == LAT2) begin
            m_valid2 = qv[0];
            if (qv[0]) m_hold2 = qd[0];
        end
        if (!m_ready()) begin
            m_mem[fill_cnt] = 32'h0;
            fill_cnt++;
        end else if (wleg) begin
            m_mem[int'(waddr)] = wdata;
        end
    endtask

    // One bus cycle: drive inputs, check all outputs, then step the model.
    task automatic cycle(input bit r_en, input logic [31:0] ra, input bit w_en,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input bit c, input bit rn);
        logic [31:0] word;
        @(negedge clk);
        rst_n = rn;
        ren   = r_en & rn;
        raddr = ra;
        wen   = w_en & rn;
        waddr = wa;
        wdata = wd;
        clr   = c;
        #1;
        if (!rn) model_reset();
        word = m_word();
        check("init_done0", 32'(idone0), 32'(m_ready()));
        check("access_err0", 32'(err0), 32'(m_err));
        check("err_addr0", erraddr0, m_err_addr);
        check("rd_count0", rdc0, m_rdc);
        check("wr_count0", wrc0, m_wrc);
        check("rvalid0", 32'(rvalid0), 32'(ren));
        check("rdata0", rdata0, ren ? word : m_hold0);
        check("init_done2", 32'(idone2), 32'(m_ready()));
        check("access_err2", 32'(err2), 32'(m_err));
        check("err_addr2", erraddr2, m_err_addr);
        check("rd_count2", rdc2, m_rdc);
        check("wr_count2", wrc2, m_wrc);
        check("rvalid2", 32'(rvalid2), 32'(m_valid2));
        check("rdata2", rdata2, m_hold2);
        $display("cyc rst_n=%0b rd=%0b@%0d wr=%0b@%0d=%h clr=%0b -> d0=%h v0=%0b d2=%h v2=%0b err=%0b",
                 rn, ren, raddr, wen, waddr, wdata, c, rdata0, rvalid0, rdata2, rvalid2, err0);
        if (rn) model_edge(word);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; ren = 1'b0; wen = 1'b0; clr = 1'b0;
        raddr = '0; waddr = '0; wdata = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        model_reset();

        // Reset, then the zero-fill.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        idle(DEPTH + 1);
        // Read every word after the fill.
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'(i), 0, 0, 0, 0, 1);
        // Write followed by a read of the same index.
        cycle(0, 0, 1, 5, 32'hA5A5_0001, 0, 1);
        cycle(1, 5, 0, 0, 0, 0, 1);
        // Small copy: preload 0..3, then copy them to 8..11, then read back.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'(i), 32'(8'h11 * (i + 1)), 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 4; i++) cycle(1, 32'(i), 1, 32'(i + 7), 32'(8'h11 * i), 0, 1);
        cycle(0, 0, 1, 11, 32'h44, 0, 1);
        for (int i = 8; i < 12; i++) cycle(1, 32'(i), 0, 0, 0, 0, 1);
        // Same-cycle read and write to the same index.
        cycle(0, 0, 1, 3, 32'h1234, 0, 1);
        cycle(1, 3, 1, 3, 32'hBEEF, 0, 1);
        cycle(1, 3, 0, 0, 0, 0, 1);
        idle(2);
        // Out-of-range read and write, then clear the error.
        cycle(1, 20, 0, 0, 0, 0, 1);
        cycle(0, 0, 1, 30, 32'hDEAD, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // Error raised in the same cycle as a clear.
        cycle(1, 17, 0, 0, 0, 0, 1);
        cycle(0, 0, 1, 25, 32'h1, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        // Back-to-back reads, then reset while responses are still in flight.
        cycle(1, 1, 0, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 0, 1);
        idle(3);
        cycle(1, 1, 0, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        // Requests during the zero-fill are flagged and ignored.
        cycle(1, 7, 1, 9, 32'h55, 0, 1);
        cycle(0, 0, 1, 4, 32'h66, 0, 1);
        idle(DEPTH);
        // Randomized traffic with occasional error clears and resets.
        for (int i = 0; i < 400; i++) begin
            bit r_en, w_en, c, rn;
            r_en = ($urandom_range(3, 0) != 0);
            w_en = ($urandom_range(1, 0) != 0);
            c    = ($urandom_range(15, 0) == 0);
            rn   = ($urandom_range(149, 0) != 0);
            cycle(r_en, 32'($urandom_range(DEPTH + 7, 0)), w_en,
                  32'($urandom_range(DEPTH + 7, 0)), $urandom(), c, rn);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
